mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_timer.sv | 20 ++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D cache memory arbiter.
package mem_arb_pkg;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 32;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              who;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } txn_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return a & {{(ADDR_W-4){1'b1}}, 4'h0};
  endfunction
endpackage

// File: rtl/mem_arb_timer.sv
// Saturating 8-bit busy-cycle watchdog; expired_o flags the cycle that reaches the limit.
module mem_arb_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] limit_i,
  output logic       expired_o
);
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        cnt_q <= '0;
    else if (clear_i)                cnt_q <= '0;
    else if (en_i && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
  end

  // cnt_q counts finished busy cycles, so the current one is number cnt_q+1
  assign expired_o = en_i && (cnt_q >= limit_i - 8'd1);
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I_cache fills and D_cache fills/write-backs onto one memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on collisions; default is D_cache priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0] ic_data,
  output logic              ic_ready,
  output logic              ic_err,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              dc_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_r,
  output logic              mem_w,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_data,
  input  logic              mem_ready
);
  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  state_t            state_q;
  txn_t              txn_q, txn_d;
  logic              gnt, expired;
  logic [LINE_W-1:0] ic_data_q, dc_data_q;
  logic              ic_rdy_q, dc_rdy_q, ic_err_q, dc_err_q, mem_r_q, mem_w_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic rr_q;  // side granted last
  assign gnt = (ic_req && dc_req) ? ~rr_q : (dc_req ? REQ_D : REQ_I);
`else
  assign gnt = dc_req ? REQ_D : REQ_I;
`endif

  always_comb begin
    txn_d.who   = gnt;
    txn_d.we    = (gnt == REQ_D) && dc_we;
    txn_d.addr  = line_align((gnt == REQ_D) ? dc_addr : ic_addr);
    txn_d.wdata = dc_wdata;
  end

  mem_arb_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q == IDLE),
    .en_i      (state_q == BUSY),
    .limit_i   (LIMIT),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      txn_q     <= '0;
      ic_data_q <= '0;
      dc_data_q <= '0;
      ic_rdy_q  <= 1'b0;
      dc_rdy_q  <= 1'b0;
      ic_err_q  <= 1'b0;
      dc_err_q  <= 1'b0;
      mem_r_q   <= 1'b0;
      mem_w_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q      <= REQ_I;
`endif
    end else begin
      ic_rdy_q <= 1'b0;
      dc_rdy_q <= 1'b0;
      ic_err_q <= 1'b0;
      dc_err_q <= 1'b0;
      case (state_q)
        IDLE: if (ic_req || dc_req) begin
          txn_q   <= txn_d;
          mem_r_q <= !txn_d.we;
          mem_w_q <= txn_d.we;
          state_q <= BUSY;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_q    <= gnt;
`endif
        end
        BUSY: if (mem_ready || expired) begin
          // a reply arriving on the timeout cycle still wins
          mem_r_q <= 1'b0;
          mem_w_q <= 1'b0;
          state_q <= DONE;
          if (txn_q.who == REQ_D) begin
            dc_data_q <= mem_ready ? mem_data : '0;
            dc_rdy_q  <= 1'b1;
            dc_err_q  <= !mem_ready;
          end else begin
            ic_data_q <= mem_ready ? mem_data : '0;
            ic_rdy_q  <= 1'b1;
            ic_err_q  <= !mem_ready;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ic_data   = ic_data_q;
  assign ic_ready  = ic_rdy_q;
  assign ic_err    = ic_err_q;
  assign dc_rdata  = dc_data_q;
  assign dc_ready  = dc_rdy_q;
  assign dc_err    = dc_err_q;
  assign mem_addr  = txn_q.addr;
  assign mem_wdata = txn_q.wdata;
  assign mem_r     = mem_r_q;
  assign mem_w     = mem_w_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected memory requests and
// cache responses; two monitors pop and compare when the DUT presents them.
module tb_mem_arbiter;
  logic         clk = 1'b0, rst = 1'b0;
  logic         ic_req = 0, dc_req = 0, dc_we = 0, mem_ready = 0;
  logic [31:0]  ic_addr = '0, dc_addr = '0, mem_addr;
  logic [127:0] dc_wdata = '0, mem_data = '0, ic_data, dc_rdata, mem_wdata;
  logic         ic_ready, ic_err, dc_ready, dc_err, mem_r, mem_w;

  typedef struct {
    logic         who;  // 0 = I, 1 = D
    logic [127:0] data;
    logic         err;
    logic         chk_data;
  } resp_t;

  typedef struct {
    logic         r, w;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic         chk_wdata;
    int           len;
  } mreq_t;

  resp_t resp_q[$];
  mreq_t mem_q[$];
  int tests = 0, fails = 0;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_data(ic_data), .ic_ready(ic_ready), .ic_err(ic_err),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_ready(dc_ready), .dc_err(dc_err),
    .mem_addr(mem_addr), .mem_r(mem_r), .mem_w(mem_w), .mem_wdata(mem_wdata),
    .mem_data(mem_data), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_mem(input logic r, input logic w, input logic [31:0] a,
                          input logic [127:0] wd, input logic cw, input int len);
    mreq_t m;
    m.r = r; m.w = w; m.addr = a; m.wdata = wd; m.chk_wdata = cw; m.len = len;
    mem_q.push_back(m);
  endtask

  task automatic push_resp(input logic who, input logic [127:0] d, input logic err, input logic cd);
    resp_t x;
    x.who = who; x.data = d; x.err = err; x.chk_data = cd;
    resp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Waits for the memory request, replies on its lat-th busy cycle.
  task automatic serve(input int lat, input logic [127:0] d);
    int k = 0;
    while (!(mem_r || mem_w) && k < 20) begin tick(); k++; end
    if (!(mem_r || mem_w)) begin
      tests++; fails++;
      $display("FAIL serve_wait: no mem request within 20 cycles");
    end else begin
      repeat (lat - 1) tick();
      mem_ready = 1'b1; mem_data = d;
      tick();
      mem_ready = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (resp_q.size() != 0 && k < 50) begin tick(); k++; end
    if (resp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL wait_idle: %0d responses outstanding after 50 cycles", resp_q.size());
    end
    repeat (2) tick();
  endtask

  // Memory-side monitor
  initial begin
    mreq_t m;
    bit act = 0, have = 0, stable = 1;
    int n = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin act = 0; continue; end
      if ((mem_r || mem_w) && !act) begin
        act = 1; n = 1; stable = 1;
        if (mem_q.size() == 0) begin
          have = 0; tests++; fails++;
          $display("FAIL mem_unexpected: r=%b w=%b addr=%h", mem_r, mem_w, mem_addr);
        end else begin
          have = 1; m = mem_q.pop_front();
          check("mem_rw", {mem_r, mem_w}, {m.r, m.w});
          check("mem_addr", mem_addr, m.addr);
          if (m.chk_wdata) check("mem_wdata", mem_wdata, m.wdata);
        end
      end else if ((mem_r || mem_w) && act) begin
        n++;
        if (have)
          stable &= (mem_addr == m.addr) && ({mem_r, mem_w} == {m.r, m.w}) &&
                    (!m.chk_wdata || mem_wdata == m.wdata);
      end else if (act) begin
        act = 0;
        if (have) begin
          check("mem_busy_len", n, m.len);
          check("mem_stable", stable, 1);
        end
      end
    end
  end

  // Cache-side monitor
  initial begin
    resp_t x;
    forever begin
      @(negedge clk);
      if (ic_ready || dc_ready) begin
        if (resp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL ready_unexpected: ic_ready=%b dc_ready=%b", ic_ready, dc_ready);
        end else begin
          x = resp_q.pop_front();
          check("ready_who", {ic_ready, dc_ready}, x.who ? 2'b01 : 2'b10);
          check("err", {ic_err, dc_err}, {!x.who && x.err, x.who && x.err});
          if (x.chk_data) check("data", x.who ? dc_rdata : ic_data, x.data);
        end
        @(negedge clk);
        check("ready_pulse_1cyc", {ic_ready, dc_ready, ic_err, dc_err}, 4'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] wb, l1, l3, l4, l5, c1, c2, c3;
    l1 = 128'h0123_4567_89AB_CDEF_0;
    wb = 128'hFFFFFFFF;
    wb = wb << 96;
    l3 = 128'h3333_0000_3333_0000_3333_0000_3333_0001;
    l4 = 128'h4444_5555_6666_7777_8888_9999_AAAA_BBBB;
    l5 = 128'h5555;
    c1 = 128'hC1; c2 = 128'hC2; c3 = 128'hC3;

    // Reset state
    #2;
    check("rst_ctrl", {mem_r, mem_w, ic_ready, dc_ready, ic_err, dc_err}, 6'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 128'h0);
    check("rst_data", {ic_data, dc_rdata}, 256'h0);
    tick();
    rst = 1'b1;

    // I fill, line-aligned address, reply on 3rd busy cycle; req dropped during BUSY
    push_mem(1, 0, 32'hFFFFFFF0, '0, 0, 3);
    push_resp(0, l1, 0, 1);
    ic_req = 1; ic_addr = 32'hFFFFFFF4;
    tick();
    ic_req = 0;
    serve(3, l1);
    wait_idle();

    // D write-back; wdata input changes after grant, latched copy must hold
    push_mem(0, 1, 32'h5A5A5FF0, wb, 1, 3);
    push_resp(1, '0, 0, 0);
    dc_req = 1; dc_we = 1; dc_addr = 32'h5A5A5FF0; dc_wdata = wb;
    tick();
    dc_req = 0; dc_we = 0; dc_wdata = '0;
    serve(3, '0);
    wait_idle();

    // D fill
    push_mem(1, 0, 32'h0000ABC0, '0, 0, 3);
    push_resp(1, l4, 0, 1);
    dc_req = 1; dc_addr = 32'h0000ABCF;
    tick();
    dc_req = 0;
    serve(3, l4);
    wait_idle();

    // mem_ready on the timeout cycle wins: no error
    push_mem(1, 0, 32'h00001230, '0, 0, 4);
    push_resp(0, l3, 0, 1);
    ic_req = 1; ic_addr = 32'h00001234;
    tick();
    ic_req = 0;
    serve(4, l3);
    wait_idle();

    // Timeout: no reply, err with zero data after 4 busy cycles
    push_mem(1, 0, 32'h00002000, '0, 0, 4);
    push_resp(0, '0, 1, 1);
    ic_req = 1; ic_addr = 32'h00002008;
    tick();
    ic_req = 0;
    wait_idle();

    // Stray mem_ready in IDLE changes nothing
    mem_ready = 1; mem_data = 128'hDEAD_BEEF;
    repeat (3) tick();
    mem_ready = 0;
    check("stray_ic_data", ic_data, 128'h0);
    check("stray_dc_rdata", dc_rdata, l4);
    check("stray_ctrl", {mem_r, mem_w, ic_ready, dc_ready, ic_err, dc_err}, 6'b0);

    // Reset during BUSY: abandoned, no ready pulse
    ic_req = 1; ic_addr = 32'h00000300;
    tick();
    ic_req = 0;
    check("busy_before_rst", mem_r, 1);
    rst = 0;
    #1;
    check("rst_mid_busy_mem_r", {mem_r, mem_w}, 2'b0);
    check("rst_mid_busy_addr", mem_addr, 32'h0);
    tick();
    rst = 1;
    repeat (3) tick();
    check("rst_mid_busy_ready", {ic_ready, dc_ready}, 2'b0);

    // Next request after reset completes normally
    push_mem(1, 0, 32'h00004440, '0, 0, 3);
    push_resp(0, l5, 0, 1);
    ic_req = 1; ic_addr = 32'h00004444;
    tick();
    ic_req = 0;
    serve(3, l5);
    wait_idle();

    // Collision: both requests held for three back-to-back rounds
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push_mem(1, 0, 32'h20000010, '0, 0, 3); push_resp(1, c1, 0, 1);
    push_mem(1, 0, 32'h10000000, '0, 0, 3); push_resp(0, c2, 0, 1);
    push_mem(1, 0, 32'h20000010, '0, 0, 3); push_resp(1, c3, 0, 1);
`else
    push_mem(1, 0, 32'h20000010, '0, 0, 3); push_resp(1, c1, 0, 1);
    push_mem(1, 0, 32'h20000010, '0, 0, 3); push_resp(1, c2, 0, 1);
    push_mem(1, 0, 32'h20000010, '0, 0, 3); push_resp(1, c3, 0, 1);
`endif
    ic_req = 1; ic_addr = 32'h10000008;
    dc_req = 1; dc_we = 0; dc_addr = 32'h2000001C;
    serve(3, c1);
    serve(3, c2);
    serve(3, c3);
    ic_req = 0; dc_req = 0;
    wait_idle();
    repeat (4) tick();

    check("resp_q_drained", resp_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
